aqed_fifo_monitor: RTL
======================

AQED_FIFO_MONITOR -- requirements
Module: aqed_fifo_monitor

Interface
REQ-001: Parameter DATA_W, default 16, meaning payload width in bits.
REQ-002: Parameter CNT_W, default 16, meaning width of the transaction counters, indices and depth.
REQ-003: Parameter CHK_DEPTH_EN, default 1, meaning 1 enables the overflow and underflow occupancy checks.
REQ-004: Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005: Port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-006: Port clk_en, input, 1, meaning the global enable; no state changes when it is 0.
REQ-007: Port in_valid, input, 1, meaning a write to the DUT is presented; in_fire = clk_en & in_valid.
REQ-008: Port in_data, input, DATA_W, meaning the write payload.
REQ-009: Port orig_sel, input, 1, meaning the current in_fire is marked as the original transaction.
REQ-010: Port dup_sel, input, 1, meaning the current in_fire is marked as the duplicate transaction.
REQ-011: Port out_valid, input, 1, meaning the DUT read data is valid.
REQ-012: Port out_ready, input, 1, meaning the read is accepted; out_fire = clk_en & out_valid & out_ready.
REQ-013: Port out_data, input, DATA_W, meaning the DUT read payload.
REQ-014: Port depth, input, CNT_W, meaning the configured FIFO depth.
REQ-015: Port occupancy, output, CNT_W, meaning count_in minus count_out, modulo 2^CNT_W.
REQ-016: Port qed_done, output, 1, meaning both the original and duplicate outputs have been captured (sticky).
REQ-017: Port qed_check, output, 1, meaning the captured outputs are equal; valid only while qed_done=1.
REQ-018: Port err, output, 3, meaning sticky error flags {cfg_err, underflow_err, overflow_err}.
REQ-019: Port state, output, 2, meaning FSM state encoding for debug.

Function
REQ-020: count_in and count_out (CNT_W bits) SHALL increment on in_fire and out_fire respectively, wrapping modulo 2^CNT_W.
REQ-021: FSM states SHALL be IDLE=0, ORIG=1, DUP=2 and DONE=3.
REQ-022: In IDLE, in_fire with orig_sel SHALL latch orig_in=in_data and orig_idx=count_in, then go to ORIG.
REQ-023: In ORIG, in_fire with dup_sel and in_data==orig_in SHALL latch dup_idx=count_in, then go to DUP.
REQ-024: In ORIG, dup_sel with mismatching data SHALL be ignored.
REQ-025: dup_sel in IDLE SHALL be ignored.
REQ-026: orig_sel outside IDLE SHALL be ignored.
REQ-027: When orig_sel and dup_sel are both high in IDLE, orig_sel SHALL win and the duplicate SHALL not be taken from the same transaction.
REQ-028: In ORIG or DUP, out_fire with count_out==orig_idx SHALL latch orig_out=out_data and set orig_got.
REQ-029: In DUP, out_fire with count_out==dup_idx SHALL latch dup_out=out_data and set dup_got.
REQ-030: An original output SHALL be captured even when it occurs before the duplicate is written.
REQ-031: When orig_got and dup_got are both set, the FSM SHALL go to DONE on the next cycle, with qed_done=1 and qed_check=(orig_out==dup_out).
REQ-032: DONE SHALL be terminal until reset; later traffic SHALL still update the counters and error flags.
REQ-033: Latency from the duplicate's out_fire to qed_done=1 SHALL be exactly 1 cycle.
REQ-034: When CHK_DEPTH_EN=1, in_fire without out_fire while occupancy==depth SHALL set overflow_err.
REQ-035: When CHK_DEPTH_EN=1, out_fire without in_fire while occupancy==0 SHALL set underflow_err.
REQ-036: Simultaneous in_fire and out_fire SHALL never set either occupancy error.
REQ-037: depth SHALL be latched on the first clk_en cycle after reset; any later change SHALL set cfg_err.
REQ-038: Index comparisons SHALL use modulo equality, so counter wrap-around SHALL NOT break matching.

Reset
REQ-039: Reset assertion SHALL immediately clear the counters, occupancy=0, state=IDLE, qed_done=0, qed_check=0, err=0 and all captured registers, including mid-transaction and in DONE.
REQ-040: The first in_fire after reset deasserts SHALL be index 0.

Verification
REQ-041: Write A5A5 with orig_sel (idx0), 1111, then A5A5 with dup_sel (idx2); read A5A5, 1111, A5A5 -> qed_done=1 one cycle after the third read, qed_check=1.
REQ-042: Same stimulus as REQ-041 but the third read returns A5A4 -> qed_done=1, qed_check=0.
REQ-043: orig_sel 0003, then dup_sel with 0004 -> state stays ORIG, qed_done stays 0.
REQ-044: depth=2, three writes with no reads -> err=3'b001 after the third write.
REQ-045: depth=2 and occupancy=2, simultaneous write and read -> no error; a read at occupancy 0 -> err=3'b010.
REQ-046: Reset asserted while in DUP -> all outputs 0 asynchronously; a new orig/dup sequence completes with qed_check=1.

Source files
------------

// File: rtl/aqed_fifo_monitor_if.sv
// Bundle between a FIFO-under-test harness and the A-QED monitor.
// The harness drives the observed write/read traffic; the monitor returns its verdict and debug state.
interface aqed_fifo_monitor_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              clk_en;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              orig_sel;
  logic              dup_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  depth;
  logic [CNT_W-1:0]  occupancy;
  logic              qed_done;
  logic              qed_check;
  logic [2:0]        err;
  logic [1:0]        state;

  modport master (
    output clk_en, in_valid, in_data, orig_sel, dup_sel,
           out_valid, out_ready, out_data, depth,
    input  occupancy, qed_done, qed_check, err, state
  );

  modport slave (
    input  clk_en, in_valid, in_data, orig_sel, dup_sel,
           out_valid, out_ready, out_data, depth,
    output occupancy, qed_done, qed_check, err, state
  );
endinterface

// File: rtl/aqed_fifo_monitor.sv
// A-QED FIFO monitor: pairs one original write with a later identical duplicate write,
// captures both read-backs and reports their equality one cycle after the last capture.
module aqed_fifo_monitor #(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 16,
  parameter int CHK_DEPTH_EN = 1
) (
  input logic                clk,
  input logic                reset,
  aqed_fifo_monitor_if.slave mon
);
  typedef enum logic [1:0] {IDLE = 2'd0, ORIG = 2'd1, DUP = 2'd2, DONE = 2'd3} state_e;

  state_e            state_q;
  logic              in_fire, out_fire;
  logic [CNT_W-1:0]  count_in_q, count_out_q, occ;
  logic [CNT_W-1:0]  depth_q, depth_eff;
  logic              depth_vld_q;
  logic [2:0]        err_q, err_d;
  logic [DATA_W-1:0] orig_in_q;
  logic [DATA_W-1:0] orig_out_q, orig_out_d, dup_out_q, dup_out_d;
  logic [CNT_W-1:0]  orig_idx_q, dup_idx_q;
  logic              orig_got_q, orig_got_d, dup_got_q, dup_got_d;
  logic              orig_cap, dup_cap;
  logic              qed_done_q, qed_check_q;

  assign in_fire   = mon.clk_en & mon.in_valid;
  assign out_fire  = mon.clk_en & mon.out_valid & mon.out_ready;
  assign occ       = count_in_q - count_out_q;
  // Before the first enabled cycle nothing is latched yet, so the live depth is the reference.
  assign depth_eff = depth_vld_q ? depth_q : mon.depth;

  always_comb begin
    err_d = err_q;
    if (mon.clk_en && depth_vld_q && (mon.depth != depth_q)) err_d[2] = 1'b1;
    if (CHK_DEPTH_EN != 0) begin
      if (in_fire && !out_fire && (occ == depth_eff)) err_d[0] = 1'b1;
      if (out_fire && !in_fire && (occ == '0))        err_d[1] = 1'b1;
    end
  end

  always_comb begin
    orig_cap   = out_fire && ((state_q == ORIG) || (state_q == DUP)) &&
                 !orig_got_q && (count_out_q == orig_idx_q);
    dup_cap    = out_fire && (state_q == DUP) && !dup_got_q && (count_out_q == dup_idx_q);
    orig_got_d = orig_got_q | orig_cap;
    dup_got_d  = dup_got_q | dup_cap;
    orig_out_d = orig_cap ? mon.out_data : orig_out_q;
    dup_out_d  = dup_cap ? mon.out_data : dup_out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_in_q  <= '0;
      count_out_q <= '0;
      depth_q     <= '0;
      depth_vld_q <= 1'b0;
      err_q       <= '0;
    end else begin
      if (in_fire)  count_in_q  <= count_in_q + CNT_W'(1);
      if (out_fire) count_out_q <= count_out_q + CNT_W'(1);
      if (mon.clk_en && !depth_vld_q) begin
        depth_q     <= mon.depth;
        depth_vld_q <= 1'b1;
      end
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      orig_in_q   <= '0;
      orig_idx_q  <= '0;
      dup_idx_q   <= '0;
      orig_out_q  <= '0;
      dup_out_q   <= '0;
      orig_got_q  <= 1'b0;
      dup_got_q   <= 1'b0;
      qed_done_q  <= 1'b0;
      qed_check_q <= 1'b0;
    end else begin
      orig_got_q <= orig_got_d;
      dup_got_q  <= dup_got_d;
      orig_out_q <= orig_out_d;
      dup_out_q  <= dup_out_d;
      case (state_q)
        IDLE: begin
          if (in_fire && mon.orig_sel) begin
            orig_in_q  <= mon.in_data;
            orig_idx_q <= count_in_q;
            state_q    <= ORIG;
          end
        end
        ORIG: begin
          if (in_fire && mon.dup_sel && (mon.in_data == orig_in_q)) begin
            dup_idx_q <= count_in_q;
            state_q   <= DUP;
          end
        end
        DUP: begin
          // Use next-state captures so the verdict appears one cycle after the final read.
          if (orig_got_d && dup_got_d) begin
            state_q     <= DONE;
            qed_done_q  <= 1'b1;
            qed_check_q <= (orig_out_d == dup_out_d);
          end
        end
        default: ;
      endcase
    end
  end

  assign mon.occupancy = occ;
  assign mon.qed_done  = qed_done_q;
  assign mon.qed_check = qed_check_q;
  assign mon.err       = err_q;
  assign mon.state     = state_q;
endmodule
